tuning_word_calc: RTL and testbench

- Upstream stage of the DDS phase accumulator.
- Converts a frequency request in Hz into the 32-bit frequency tuning word FTW = floor(frequency * 2^PHASE_BITS / CLK_FREQ) using a multi-cycle restoring divider, so no vendor divider IP is needed.
- Result is held stable on tuning_word, which feeds the accumulator's increment input, and a one-cycle tw_valid pulse marks each update.

---
 rtl/dds_pkg.sv | 33 +++
 rtl/tuning_word_calc_udiv_step.sv | 32 +++
 rtl/tuning_word_calc.sv | 163 ++++++++++++++++
 tb/tb_tuning_word_calc.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// ---------------------------------------------------------------------------
// dds_pkg
// Shared constants and types for the DDS front end.
//   CLK_FREQ   : system clock in Hz, the constant divisor of the FTW division
//   PHASE_BITS : tuning-word / accumulator width, also the divider step count
//   FREQ_BITS  : width of a frequency request in Hz
// Types:
//   phase_t     : tuning word
//   freq_t      : frequency request
//   rem_t       : divider remainder (one bit wider than a tuning word)
//   twc_state_t : tuning_word_calc FSM states
// ---------------------------------------------------------------------------
package dds_pkg;

  localparam int unsigned CLK_FREQ   = 32'd100_000_000;
  localparam int          PHASE_BITS = 32;
  localparam int          FREQ_BITS  = 16;
  localparam int          REM_BITS   = PHASE_BITS + 1;

  typedef logic [PHASE_BITS-1:0] phase_t;
  typedef logic [FREQ_BITS-1:0]  freq_t;
  typedef logic [REM_BITS-1:0]   rem_t;

  // Divisor widened to remainder width so compares and subtracts match.
  localparam rem_t CLK_FREQ_REM = rem_t'(CLK_FREQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    ROUND = 2'd2
  } twc_state_t;

endpackage

// File: rtl/tuning_word_calc_udiv_step.sv
// ---------------------------------------------------------------------------
// udiv_step
// One combinational restoring-division step against the constant CLK_FREQ.
//   rem_in  : current partial remainder (always < CLK_FREQ)
//   rem_out : remainder after this step
//   q_bit   : quotient bit produced by this step
// ---------------------------------------------------------------------------
module udiv_step
  import dds_pkg::*;
(
  input  rem_t rem_in,
  output rem_t rem_out,
  output logic q_bit
);

  rem_t shifted;

  // Shift left one place and subtract the divisor when it fits.
  // The shifted value is conceptually one bit wider than rem_t; the bit
  // shifted out (rem_in MSB) forces a subtract, and the modular difference
  // is then exact because the true result is below CLK_FREQ.
  always_comb begin
    shifted = {rem_in[PHASE_BITS-1:0], 1'b0};
    q_bit   = rem_in[PHASE_BITS] | (shifted >= CLK_FREQ_REM);
    if (q_bit) begin
      rem_out = shifted - CLK_FREQ_REM;
    end else begin
      rem_out = shifted;
    end
  end

endmodule

// File: rtl/tuning_word_calc.sv
// ---------------------------------------------------------------------------
// tuning_word_calc
// Converts a frequency request (Hz) into the DDS frequency tuning word
//   FTW = floor(frequency * 2^PHASE_BITS / CLK_FREQ)
// using a PHASE_BITS-step restoring divider. tuning_word only changes on a
// completion edge and is held otherwise; tw_valid pulses for one cycle then.
//
// Ports:
//   clock       : system clock, rising edge
//   reset       : asynchronous, active-high
//   frequency   : requested frequency in Hz (FREQ_BITS, unsigned)
//   freq_valid  : request valid
//   freq_ready  : idle and able to accept a request
//   tuning_word : last computed FTW (PHASE_BITS)
//   tw_valid    : one-cycle pulse when tuning_word updates
//   busy        : division in progress
//
// Build option:
//   TUNING_ROUND_NEAREST_EN : adds a ROUND state after the divide that rounds
//   the quotient to nearest (saturating), adding one cycle of latency.
// ---------------------------------------------------------------------------
module tuning_word_calc
  import dds_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  freq_t frequency,
  input  logic  freq_valid,
  output logic  freq_ready,
  output phase_t tuning_word,
  output logic  tw_valid,
  output logic  busy
);

  localparam int CNT_BITS = $clog2(PHASE_BITS + 1);
  typedef logic [CNT_BITS-1:0] cnt_t;
  localparam cnt_t LAST_ITER = cnt_t'(PHASE_BITS - 1);

  twc_state_t state_q, state_d;
  rem_t       rem_q, rem_d;
  phase_t     quo_q, quo_d;
  cnt_t       cnt_q, cnt_d;
  phase_t     tw_q, tw_d;
  logic       tw_valid_q, tw_valid_d;
  logic       busy_q, busy_d;
  logic       ready_q, ready_d;

  rem_t       step_rem;
  logic       step_bit;

  udiv_step u_step (
    .rem_in  (rem_q),
    .rem_out (step_rem),
    .q_bit   (step_bit)
  );

`ifdef TUNING_ROUND_NEAREST_EN
  logic   round_up;
  phase_t rounded;

  // Round-to-nearest on the final remainder; saturate instead of wrapping.
  always_comb begin
    round_up = ({rem_q[PHASE_BITS-1:0], 1'b0} >= CLK_FREQ_REM);
    if (round_up && (quo_q != {PHASE_BITS{1'b1}})) begin
      rounded = quo_q + phase_t'(1);
    end else begin
      rounded = quo_q;
    end
  end
`endif

  // Next-state and datapath logic for the handshake/divide FSM.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    tw_d       = tw_q;
    tw_valid_d = 1'b0;
    busy_d     = busy_q;
    ready_d    = ready_q;

    case (state_q)
      IDLE: begin
        if (freq_valid && ready_q) begin
          rem_d   = rem_t'(frequency);
          quo_d   = '0;
          cnt_d   = '0;
          state_d = DIV;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      DIV: begin
        rem_d = step_rem;
        quo_d = (quo_q << 1) | phase_t'(step_bit);
        cnt_d = cnt_q + cnt_t'(1);
        if (cnt_q == LAST_ITER) begin
`ifdef TUNING_ROUND_NEAREST_EN
          state_d = ROUND;
`else
          tw_d       = quo_d;
          tw_valid_d = 1'b1;
          busy_d     = 1'b0;
          ready_d    = 1'b1;
          state_d    = IDLE;
`endif
        end else begin
          state_d = DIV;
        end
      end

`ifdef TUNING_ROUND_NEAREST_EN
      ROUND: begin
        tw_d       = rounded;
        tw_valid_d = 1'b1;
        busy_d     = 1'b0;
        ready_d    = 1'b1;
        state_d    = IDLE;
      end
`endif

      default: begin
        // Unreachable encodings recover to a clean idle.
        state_d = IDLE;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight division.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      tw_q       <= '0;
      tw_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      tw_q       <= tw_d;
      tw_valid_q <= tw_valid_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

  assign freq_ready  = ready_q;
  assign tuning_word = tw_q;
  assign tw_valid    = tw_valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_tuning_word_calc.sv
// ---------------------------------------------------------------------------
// tb_tuning_word_calc
// Scoreboard bench: each accepted request pushes its expected tuning word and
// the cycle its tw_valid pulse is due; a monitor pops on every tw_valid.
// ---------------------------------------------------------------------------
module tb_tuning_word_calc;
  import dds_pkg::*;

`ifdef TUNING_ROUND_NEAREST_EN
  localparam int LAT = PHASE_BITS + 1;
  localparam phase_t EXP_1000  = 32'd42950;
  localparam phase_t EXP_65535 = 32'd2814707;
  localparam phase_t EXP_1     = 32'd43;
`else
  localparam int LAT = PHASE_BITS;
  localparam phase_t EXP_1000  = 32'd42949;
  localparam phase_t EXP_65535 = 32'd2814706;
  localparam phase_t EXP_1     = 32'd42;
`endif
  localparam phase_t EXP_5000 = 32'd214748;

  typedef struct {
    phase_t tw;
    int     due;
  } exp_t;

  logic   clock;
  logic   reset;
  freq_t  frequency;
  logic   freq_valid;
  logic   freq_ready;
  phase_t tuning_word;
  logic   tw_valid;
  logic   busy;

  exp_t   sb[$];
  int     cyc;
  int     n_checks;
  int     n_fail;

  tuning_word_calc dut (
    .clock       (clock),
    .reset       (reset),
    .frequency   (frequency),
    .freq_valid  (freq_valid),
    .freq_ready  (freq_ready),
    .tuning_word (tuning_word),
    .tw_valid    (tw_valid),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Edge counter: after rising edge k, cyc == k.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every tw_valid must match the head of the scoreboard in value and timing.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && tw_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_tw_valid: tw_valid at cycle %0d, expected none", cyc);
        end else begin
          e = sb.pop_front();
          check("tuning_word", tuning_word, e.tw);
          check("latency_cycle", cyc, e.due);
        end
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (freq_ready !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (freq_ready !== 1'b1) check("ready_timeout", {31'd0, freq_ready}, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("scoreboard_drained", sb.size(), 32'd0);
  endtask

  // Issue one request at a negedge where freq_ready is high.
  task automatic send(input freq_t f, input phase_t exp_tw, input bit expect_result);
    exp_t e;
    wait_ready();
    frequency  = f;
    freq_valid = 1'b1;
    if (expect_result) begin
      e.tw  = exp_tw;
      e.due = cyc + 1 + LAT;
      sb.push_back(e);
    end
    @(negedge clock);
    freq_valid = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   start;
    n_checks   = 0;
    n_fail     = 0;
    cyc        = 0;
    reset      = 1'b1;
    frequency  = '0;
    freq_valid = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    check("reset_tuning_word", tuning_word, 32'd0);
    check("reset_tw_valid", {31'd0, tw_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_freq_ready", {31'd0, freq_ready}, 32'd1);

    // Directed values.
    send(16'd1000, EXP_1000, 1'b1);
    @(negedge clock);
    check("busy_during_div", {31'd0, busy}, 32'd1);
    drain();
    send(16'd65535, EXP_65535, 1'b1);
    drain();
    send(16'd1, EXP_1, 1'b1);
    drain();

    // Zero request, with a request presented while busy that must be ignored.
    send(16'd0, 32'd0, 1'b1);
    @(negedge clock);
    frequency  = 16'd5000;
    freq_valid = 1'b1;
    check("ready_low_while_busy", {31'd0, freq_ready}, 32'd0);
    repeat (3) @(negedge clock);
    freq_valid = 1'b0;
    drain();
    repeat (2) @(negedge clock);
    check("ignored_req_tw_zero", tuning_word, 32'd0);
    send(16'd5000, EXP_5000, 1'b1);
    drain();

    // Reset in the middle of a division: nothing may complete.
    send(16'd1000, 32'd0, 1'b0);
    repeat (15) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("midreset_tuning_word", tuning_word, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_freq_ready", {31'd0, freq_ready}, 32'd1);
    check("midreset_tw_valid", {31'd0, tw_valid}, 32'd0);
    repeat (LAT + 5) @(negedge clock);
    send(16'd1000, EXP_1000, 1'b1);
    drain();

    // Back-to-back: valid held high, three accepts every LAT+1 cycles.
    wait_ready();
    frequency  = 16'd1000;
    freq_valid = 1'b1;
    start      = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      e.tw  = EXP_1000;
      e.due = start + i * (LAT + 1) + LAT;
      sb.push_back(e);
    end
    repeat (2 * LAT + 3) @(negedge clock);
    freq_valid = 1'b0;
    drain();
    repeat (LAT + 5) @(negedge clock);
    check("no_extra_results", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
